// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The ovf signal exists only when NSA_OVF_DETECT_EN is defined.
interface nibble_serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
`ifdef NSA_OVF_DETECT_EN
   logic             ovf;
`endif

   modport master (
`ifdef NSA_OVF_DETECT_EN
      input  ovf,
`endif
      output in_valid, a, b, c_in, out_ready,
      input  in_ready, out_valid, sum, c_out
   );

   modport slave (
`ifdef NSA_OVF_DETECT_EN
      output ovf,
`endif
      input  in_valid, a, b, c_in, out_ready,
      output in_ready, out_valid, sum, c_out
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder pushing one nibble per clock through a 4-bit ripple-carry adder.
// Optional signed-overflow output enabled by defining NSA_OVF_DETECT_EN.
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   nibble_serial_adder_if.slave bus
);
   localparam int N    = WIDTH / 4;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] opA_q, opA_d;
   logic [WIDTH-1:0] opB_q, opB_d;
   logic [WIDTH-1:0] sum_q, sum_d;
`ifdef NSA_OVF_DETECT_EN
   logic             aMsb_q, aMsb_d;
   logic             bMsb_q, bMsb_d;
`endif

   logic [3:0]       nibA;
   logic [3:0]       nibB;
   logic [3:0]       rcaSum;
   logic [4:0]       rcaChain;

   // The single shared 4-bit ripple-carry stage, fed from the current nibble and carry register
   always_comb begin
      nibA        = opA_q[4*idx_q +: 4];
      nibB        = opB_q[4*idx_q +: 4];
      rcaChain    = '0;
      rcaSum      = '0;
      rcaChain[0] = carry_q;
      for (int i = 0; i < 4; i++) begin
         rcaSum[i]     = nibA[i] ^ nibB[i] ^ rcaChain[i];
         rcaChain[i+1] = (nibA[i] & nibB[i]) | (rcaChain[i] & (nibA[i] ^ nibB[i]));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         opA_q   <= '0;
         opB_q   <= '0;
         sum_q   <= '0;
`ifdef NSA_OVF_DETECT_EN
         aMsb_q  <= 1'b0;
         bMsb_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         sum_q   <= sum_d;
`ifdef NSA_OVF_DETECT_EN
         aMsb_q  <= aMsb_d;
         bMsb_q  <= bMsb_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      sum_d   = sum_q;
`ifdef NSA_OVF_DETECT_EN
      aMsb_d  = aMsb_q;
      bMsb_d  = bMsb_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               opA_d   = bus.a;
               opB_d   = bus.b;
               carry_d = bus.c_in;
               idx_d   = '0;
`ifdef NSA_OVF_DETECT_EN
               aMsb_d  = bus.a[WIDTH-1];
               bMsb_d  = bus.b[WIDTH-1];
`endif
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[4*idx_q +: 4] = rcaSum;
            carry_d             = rcaChain[4];
            if (idx_q == IDXW'(N - 1)) begin
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.c_out     = carry_q;
`ifdef NSA_OVF_DETECT_EN
   assign bus.ovf = (state_q == DONE) && (aMsb_q == bMsb_q) && (sum_q[WIDTH-1] != aMsb_q);
`endif
endmodule
